// File: rtl/alu_issue_seq.sv
// Issue sequencer for the 2-bit-control datapath ALU: accepts one R-type op per
// handshake, drives registered operands/control, captures the result a cycle later.
module alu_issue_seq #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_funct,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [1:0]    alu_ctrl,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zflag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          out_eq,
    output logic          out_zero,
    output logic          out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CTRL_AND = 2'b00,
        CTRL_XOR = 2'b01,
        CTRL_ADD = 2'b10,
        CTRL_SUB = 2'b11
    } ctrl_e;

    state_e        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] alu_a_q;
    logic [DW-1:0] alu_b_q;
    ctrl_e         alu_ctrl_q;
    logic [DW-1:0] out_result_q;
    logic          out_eq_q;
    logic          out_zero_q;
    logic          out_err_q;

    logic          legal_d;
    ctrl_e         ctrl_d;

    // NOTE: every output of always_comb gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        legal_d = 1'b1;
        ctrl_d  = CTRL_AND;
        case (in_funct)
            6'h24:        ctrl_d = CTRL_AND;
            6'h26:        ctrl_d = CTRL_XOR;
            6'h20, 6'h21: ctrl_d = CTRL_ADD;
            6'h22, 6'h23: ctrl_d = CTRL_SUB;
            default:      legal_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= CTRL_AND;
            out_result_q <= '0;
            out_eq_q     <= 1'b0;
            out_zero_q   <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (legal_d) begin
                            alu_a_q    <= in_a;
                            alu_b_q    <= in_b;
                            alu_ctrl_q <= ctrl_d;
                            state_q    <= EXEC;
                        end else begin
                            // Illegal op skips the ALU and answers immediately.
                            out_result_q <= '0;
                            out_eq_q     <= 1'b0;
                            out_zero_q   <= 1'b1;
                            out_err_q    <= 1'b1;
                            out_valid_q  <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end
                end
                EXEC: begin
                    out_result_q <= alu_result;
                    out_eq_q     <= alu_zflag;
                    out_zero_q   <= (alu_result == '0);
                    out_err_q    <= 1'b0;
                    out_valid_q  <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: begin
                    // in_ready rises only after the handshake edge: no back-to-back accept.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign out_result = out_result_q;
    assign out_eq     = out_eq_q;
    assign out_zero   = out_zero_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: models the external ALU and checks responses
// against a scoreboard of expected results pushed at each accepted request.
module tb_alu_issue_seq;

    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] result;
        logic          eq;
        logic          zero;
        logic          err;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_funct;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_ctrl;
    logic [DW-1:0] alu_result;
    logic          alu_zflag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_eq;
    logic          out_zero;
    logic          out_err;

    int    errors = 0;
    int    checks = 0;
    resp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_seq #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct   (in_funct),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zflag  (alu_zflag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_eq     (out_eq),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    // External combinational ALU
    always_comb begin
        case (alu_ctrl)
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a ^ alu_b;
            2'b10:   alu_result = alu_a + alu_b;
            default: alu_result = alu_a - alu_b;
        endcase
        alu_zflag = (alu_a == alu_b);
    end

    function automatic resp_t ref_op(input logic [5:0] f, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
        resp_t r;
        r.err = 1'b0;
        r.eq  = (a == b);
        case (f)
            6'h24:        r.result = a & b;
            6'h26:        r.result = a ^ b;
            6'h20, 6'h21: r.result = a + b;
            6'h22, 6'h23: r.result = a - b;
            default: begin
                r.result = '0;
                r.eq     = 1'b0;
                r.err    = 1'b1;
            end
        endcase
        r.zero = (r.result == '0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [5:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        in_funct = f;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(ref_op(f, a, b));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency and fields, then completes the handshake.
    task automatic expect_resp(input string tag, input int lat);
        int    n = 0;
        resp_t e;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
            return;
        end
        check({tag, "_latency"}, n, lat);
        if (sb.size() == 0) begin
            check({tag, "_unexpected"}, sb.size(), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_result"}, out_result, e.result);
        check({tag, "_eq"},     {31'd0, out_eq},   {31'd0, e.eq});
        check({tag, "_zero"},   {31'd0, out_zero}, {31'd0, e.zero});
        check({tag, "_err"},    {31'd0, out_err},  {31'd0, e.err});
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_funct  = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",   {31'd0, in_ready},  32'd1);
        check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_alu_a",      alu_a, 32'd0);
        check("rst_alu_b",      alu_b, 32'd0);
        check("rst_alu_ctrl",   {30'd0, alu_ctrl}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_flags",  {29'd0, out_eq, out_zero, out_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Add with signed overflow wraps silently
        send(6'h20, 32'h7FFF_FFFF, 32'h1);
        check("add_ctrl",     {30'd0, alu_ctrl}, 32'd2);
        check("add_in_ready", {31'd0, in_ready}, 32'd0);
        expect_resp("add", 1);

        // Sub with equal operands, then subu borrow
        send(6'h22, 32'h1234, 32'h1234);
        check("sub_ctrl", {30'd0, alu_ctrl}, 32'd3);
        expect_resp("sub_eq", 1);
        send(6'h23, 32'h0, 32'h1);
        expect_resp("subu", 1);

        // AND then XOR on the same operands
        send(6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and_ctrl", {30'd0, alu_ctrl}, 32'd0);
        expect_resp("and", 1);
        send(6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("xor_ctrl", {30'd0, alu_ctrl}, 32'd1);
        expect_resp("xor", 1);

        // Illegal funct: one-cycle response, ALU inputs untouched
        send(6'h08, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        check("ill_alu_a",    alu_a, 32'hF0F0_F0F0);
        check("ill_alu_b",    alu_b, 32'hFF00_FF00);
        check("ill_alu_ctrl", {30'd0, alu_ctrl}, 32'd1);
        expect_resp("illegal", 0);

        // Backpressure with new requests presented while busy
        out_ready = 1'b0;
        send(6'h21, 32'd5, 32'd7);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_funct = 6'h20;
            in_a     = 32'(i + 100);
            in_b     = 32'(i);
            check("bp_out_valid",  {31'd0, out_valid}, 32'd1);
            check("bp_in_ready",   {31'd0, in_ready},  32'd0);
            check("bp_out_result", out_result, 32'd12);
            check("bp_alu_a",      alu_a, 32'd5);
            @(negedge clk);
        end
        in_valid = 1'b0;
        expect_resp("bp", 0);
        send(6'h22, 32'd10, 32'd3);
        expect_resp("after_bp", 1);

        // Reset during EXEC discards the operation
        send(6'h20, 32'd1, 32'd2);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check("abort_alu_ctrl",  {30'd0, alu_ctrl},  32'd0);
        check("abort_alu_a",     alu_a, 32'd0);

        // Reset and request in the same cycle: request not accepted
        in_valid = 1'b1;
        in_funct = 6'h20;
        in_a     = 32'd9;
        in_b     = 32'd9;
        @(negedge clk);
        check("rst_req_alu_a",    alu_a, 32'd0);
        check("rst_req_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        rst      = 1'b0;
        seen     = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_resp", seen, 32'd0);

        // Normal operation resumes
        send(6'h21, 32'hFFFF_FFFF, 32'h2);
        expect_resp("resume", 1);
        check("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
